sram_boot_loader: RTL and testbench

Sequencer that owns the shared 21-bit SRAM port during ROM loading. It accepts 32-bit boot words from the control module over the `host_bootdata` req/ack handshake and writes each word as four byte-wide SRAM writes at consecutive addresses. It holds the CPC machine in reset until `ROM_BYTES` bytes are written, then hands the SRAM port to the machine and raises `host_rom_initialised`. It sits between CtrlModule, the `cpc` core and the SRAM pins.

---
 rtl/sram_boot_loader.sv | 155 +++++++++++++++
 tb/tb_sram_boot_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_boot_loader.sv
// sram_boot_loader: streams 32-bit boot words into SRAM one byte at a time while the
// machine is held in reset, then hands the SRAM port to the machine for good.
module sram_boot_loader #(
    parameter int unsigned ROM_BYTES = 65536,
    parameter logic [20:0] BASE_ADDR = 21'h000000,
    parameter int unsigned WR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] host_bootdata,
    input  logic        host_bootdata_req,
    output logic        host_bootdata_ack,
    output logic        host_rom_initialised,
    output logic        cpu_hold,
    input  logic [20:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we_n,
    output logic [20:0] sram_addr,
    output logic [7:0]  sram_dout,
    output logic        sram_dout_oe,
    output logic        sram_we_n
);
    localparam int REM_W  = $clog2(ROM_BYTES + 1);
    localparam int WCNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [REM_W-1:0]  REM_INIT  = REM_W'(ROM_BYTES);
    localparam logic [REM_W-1:0]  REM_LAST  = REM_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [31:0]        r_word;
    logic [1:0]         r_byteSel;
    logic [20:0]        r_addr;
    logic [REM_W-1:0]   r_remaining;
    logic [WCNT_W-1:0]  r_wcnt;
    logic [7:0]         w_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (host_bootdata_req) begin
                    w_nextState = CAPTURE;
                end
            end
            CAPTURE: w_nextState = SETUP;
            SETUP:   w_nextState = STROBE;
            STROBE: begin
                if (r_wcnt == WCNT_LAST) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (r_remaining == REM_LAST) begin
                    w_nextState = DONE;
                end else if (r_byteSel == 2'd3) begin
                    w_nextState = IDLE;
                end else begin
                    w_nextState = SETUP;
                end
            end
            DONE:    w_nextState = DONE;
            default: w_nextState = IDLE;
        endcase
    end

    // The address and byte count advance only in HOLD, so a reset mid-word restarts cleanly at byte 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word      <= '0;
            r_byteSel   <= '0;
            r_addr      <= BASE_ADDR;
            r_remaining <= REM_INIT;
            r_wcnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (host_bootdata_req) begin
                        r_word    <= host_bootdata;
                        r_byteSel <= 2'd0;
                    end
                end
                SETUP: r_wcnt <= '0;
                STROBE: begin
                    if (r_wcnt != WCNT_LAST) begin
                        r_wcnt <= r_wcnt + WCNT_W'(1);
                    end
                end
                HOLD: begin
                    r_addr      <= r_addr + 21'd1;
                    r_remaining <= r_remaining - REM_LAST;
                    if ((r_remaining != REM_LAST) && (r_byteSel != 2'd3)) begin
                        r_byteSel <= r_byteSel + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (r_byteSel)
            2'd0:    w_byte = r_word[31:24];
            2'd1:    w_byte = r_word[23:16];
            2'd2:    w_byte = r_word[15:8];
            default: w_byte = r_word[7:0];
        endcase
    end

    // Everything is a decode of registered state except the DONE passthrough to the machine.
    always_comb begin
        host_bootdata_ack    = (r_state == CAPTURE);
        host_rom_initialised = 1'b0;
        cpu_hold             = 1'b1;
        sram_addr            = r_addr;
        sram_dout            = w_byte;
        sram_dout_oe         = 1'b0;
        sram_we_n            = 1'b1;
        case (r_state)
            SETUP, HOLD: begin
                sram_dout_oe = 1'b1;
            end
            STROBE: begin
                sram_dout_oe = 1'b1;
                sram_we_n    = 1'b0;
            end
            DONE: begin
                host_rom_initialised = 1'b1;
                cpu_hold             = 1'b0;
                sram_addr            = cpu_addr;
                sram_dout            = cpu_wdata;
                sram_we_n            = cpu_we_n;
                sram_dout_oe         = ~cpu_we_n;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sram_boot_loader.sv
// Bench for sram_boot_loader: instance A (8 bytes at 0x100, 2-clock strobes) and
// instance B (4 bytes at 0x1FFFFE, 3-clock strobes) checked by a write/ack scoreboard.
module tb_sram_boot_loader;
    typedef struct packed {
        logic        dut;
        logic [20:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetA = 1'b1, reqA = 1'b0, cpuWeA = 1'b1;
    logic [31:0] bootA = '0;
    logic [20:0] cpuAddrA = '0;
    logic [7:0]  cpuWdataA = '0;
    logic        ackA, initA, holdA, oeA, weA;
    logic [20:0] sramAddrA;
    logic [7:0]  sramDoutA;

    logic        resetB = 1'b1, reqB = 1'b0, cpuWeB = 1'b1;
    logic [31:0] bootB = '0;
    logic [20:0] cpuAddrB = '0;
    logic [7:0]  cpuWdataB = '0;
    logic        ackB, initB, holdB, oeB, weB;
    logic [20:0] sramAddrB;
    logic [7:0]  sramDoutB;

    sram_boot_loader #(.ROM_BYTES(8), .BASE_ADDR(21'h000100), .WR_CYCLES(2)) dutA (
        .clk(clock), .reset(resetA),
        .host_bootdata(bootA), .host_bootdata_req(reqA), .host_bootdata_ack(ackA),
        .host_rom_initialised(initA), .cpu_hold(holdA),
        .cpu_addr(cpuAddrA), .cpu_wdata(cpuWdataA), .cpu_we_n(cpuWeA),
        .sram_addr(sramAddrA), .sram_dout(sramDoutA), .sram_dout_oe(oeA), .sram_we_n(weA)
    );

    sram_boot_loader #(.ROM_BYTES(4), .BASE_ADDR(21'h1FFFFE), .WR_CYCLES(3)) dutB (
        .clk(clock), .reset(resetB),
        .host_bootdata(bootB), .host_bootdata_req(reqB), .host_bootdata_ack(ackB),
        .host_rom_initialised(initB), .cpu_hold(holdB),
        .cpu_addr(cpuAddrB), .cpu_wdata(cpuWdataB), .cpu_we_n(cpuWeB),
        .sram_addr(sramAddrB), .sram_dout(sramDoutB), .sram_dout_oe(oeB), .sram_we_n(weB)
    );

    wr_t         expQ[$];
    int          ackQ[$];
    int          passCount = 0;
    int          totalChecks = 0;
    int          ackCnt[2] = '{0, 0};
    int          lowCnt[2] = '{0, 0};
    int          wrCyc[2] = '{2, 3};
    logic        prevWe[2] = '{1'b1, 1'b1};
    logic        prevAck[2] = '{1'b0, 1'b0};
    logic        inPulse[2] = '{1'b0, 1'b0};
    logic [20:0] prevAddr[2];
    logic [7:0]  prevDout[2];
    wr_t         cur[2];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic failEvent(input string name, input string act, input string exp);
        totalChecks++;
        $display("[TB] FAIL %s: got %s, expected %s", name, act, exp);
    endtask

    task automatic pushWrite(input int k, input logic [20:0] addr, input logic [7:0] data);
        wr_t e;
        e.dut  = 1'(k);
        e.addr = addr;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic pushWord(input int k, input logic [20:0] base, input logic [31:0] w);
        for (int i = 0; i < 4; i++) pushWrite(k, base + 21'(i), w[31 - 8*i -: 8]);
        ackQ.push_back(k);
    endtask

    // One scoreboard step per DUT per falling edge: pops on ack and on each we_n fall while loading.
    task automatic monStep(input int k, input logic rst, input logic hold, input logic we,
                           input logic oe, input logic [20:0] addr, input logic [7:0] dout,
                           input logic ack);
        string tag;
        tag = (k == 0) ? "A" : "B";
        if (rst) begin
            inPulse[k] = 1'b0;
        end else begin
            if (ack && prevAck[k]) failEvent({tag, " ack width"}, "2+ clocks", "1 clock");
            if (ack && !prevAck[k]) begin
                ackCnt[k]++;
                if (ackQ.size() == 0) failEvent({tag, " ack"}, "ack pulse", "no ack");
                else checkOutput({tag, " ack owner"}, 32'(ackQ.pop_front()), 32'(k));
            end
            if (!hold) begin
                inPulse[k] = 1'b0;
            end else if (!we && prevWe[k]) begin
                if (expQ.size() == 0) begin
                    failEvent({tag, " write"}, "unexpected write", "no write");
                    inPulse[k] = 1'b0;
                end else begin
                    cur[k] = expQ.pop_front();
                    checkOutput({tag, " wr owner"}, 32'(cur[k].dut), 32'(k));
                    checkOutput({tag, " wr addr"}, 32'(addr), 32'(cur[k].addr));
                    checkOutput({tag, " wr data"}, 32'(dout), 32'(cur[k].data));
                    checkOutput({tag, " setup addr"}, 32'(prevAddr[k]), 32'(cur[k].addr));
                    checkOutput({tag, " setup data"}, 32'(prevDout[k]), 32'(cur[k].data));
                    checkOutput({tag, " strobe oe"}, 32'(oe), 32'd1);
                    inPulse[k] = 1'b1;
                    lowCnt[k]  = 1;
                end
            end else if (!we && inPulse[k]) begin
                lowCnt[k]++;
                checkOutput({tag, " strobe addr"}, 32'(addr), 32'(cur[k].addr));
                checkOutput({tag, " strobe data"}, 32'(dout), 32'(cur[k].data));
            end else if (we && !prevWe[k] && inPulse[k]) begin
                checkOutput({tag, " we_n width"}, 32'(lowCnt[k]), 32'(wrCyc[k]));
                checkOutput({tag, " hold addr"}, 32'(addr), 32'(cur[k].addr));
                checkOutput({tag, " hold data"}, 32'(dout), 32'(cur[k].data));
                checkOutput({tag, " hold oe"}, 32'(oe), 32'd1);
                inPulse[k] = 1'b0;
            end
        end
        prevWe[k]   = we;
        prevAck[k]  = ack;
        prevAddr[k] = addr;
        prevDout[k] = dout;
    endtask

    always @(negedge clock) begin
        monStep(0, resetA, holdA, weA, oeA, sramAddrA, sramDoutA, ackA);
        monStep(1, resetB, holdB, weB, oeB, sramAddrB, sramDoutB, ackB);
    end

    // Holds req high, swaps in the second word once the first is captured, and measures
    // the edges from the first req sample to the edge that raises host_rom_initialised.
    task automatic applyStimulus(input int k, input logic [31:0] w0, input logic [31:0] w1,
                                 input int expElapsed);
        int elapsed;
        elapsed = 0;
        if (k == 0) begin bootA = w0; reqA = 1'b1; end
        else begin bootB = w0; reqB = 1'b1; end
        @(posedge clock);
        while (!((k == 0) ? initA : initB) && elapsed < 200) begin
            @(posedge clock);
            #1;
            elapsed++;
            if (elapsed == 2) begin
                if (k == 0) bootA = w1;
                else bootB = w1;
            end
        end
        checkOutput((k == 0) ? "A init latency" : "B init latency", 32'(elapsed), 32'(expElapsed));
        @(negedge clock);
        if (k == 0) reqA = 1'b0;
        else reqB = 1'b0;
    endtask

    task automatic sendSparse(input logic [31:0] w);
        int   n;
        logic seen;
        bootA = w;
        reqA  = 1'b1;
        n = 0;
        while (!ackA && n < 20) begin @(negedge clock); n++; end
        checkOutput("A sparse ack", 32'(ackA), 32'd1);
        reqA = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!(seen && !oeA) && n < 60) begin
            @(negedge clock);
            if (oeA) seen = 1'b1;
            n++;
        end
        checkOutput("A sparse word end", 32'(seen && !oeA), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        @(negedge clock);
        checkOutput("A rst ack", 32'(ackA), 32'd0);
        checkOutput("A rst init", 32'(initA), 32'd0);
        checkOutput("A rst hold", 32'(holdA), 32'd1);
        checkOutput("A rst we_n", 32'(weA), 32'd1);
        checkOutput("A rst oe", 32'(oeA), 32'd0);
        checkOutput("A rst addr", 32'(sramAddrA), 32'h100);
        checkOutput("A rst dout", 32'(sramDoutA), 32'h0);
        checkOutput("B rst addr", 32'(sramAddrB), 32'h1FFFFE);
        checkOutput("B rst hold", 32'(holdB), 32'd1);
        resetA = 1'b0;
        @(negedge clock);

        // Two 17-clock words plus the one IDLE clock where req is re-sampled: 35 edges.
        pushWrite(0, 21'h100, 8'hA1); pushWrite(0, 21'h101, 8'hB2);
        pushWrite(0, 21'h102, 8'hC3); pushWrite(0, 21'h103, 8'hD4);
        pushWrite(0, 21'h104, 8'h11); pushWrite(0, 21'h105, 8'h22);
        pushWrite(0, 21'h106, 8'h33); pushWrite(0, 21'h107, 8'h44);
        ackQ.push_back(0); ackQ.push_back(0);
        applyStimulus(0, 32'hA1B2C3D4, 32'h11223344, 35);
        checkOutput("A done init", 32'(initA), 32'd1);
        checkOutput("A done hold", 32'(holdA), 32'd0);
        checkOutput("A writes left", 32'(expQ.size()), 32'd0);
        checkOutput("A ack count", 32'(ackCnt[0]), 32'd2);

        cpuAddrA = 21'h1ABCD; cpuWdataA = 8'h5A; cpuWeA = 1'b0;
        #1;
        checkOutput("A pass addr", 32'(sramAddrA), 32'h1ABCD);
        checkOutput("A pass dout", 32'(sramDoutA), 32'h5A);
        checkOutput("A pass oe", 32'(oeA), 32'd1);
        checkOutput("A pass we_n", 32'(weA), 32'd0);
        reqA = 1'b1;
        repeat (10) @(negedge clock);
        checkOutput("A ack after done", 32'(ackCnt[0]), 32'd2);
        reqA = 1'b0; cpuWeA = 1'b1;
        @(negedge clock);
        checkOutput("A pass oe off", 32'(oeA), 32'd0);

        resetA = 1'b1;
        @(negedge clock);
        resetA = 1'b0;
        pushWord(0, 21'h100, 32'h0F1E2D3C);
        pushWord(0, 21'h104, 32'h4B5A6978);
        sendSparse(32'h0F1E2D3C);
        repeat (5) begin
            @(negedge clock);
            checkOutput("A gap oe", 32'(oeA), 32'd0);
            checkOutput("A gap we_n", 32'(weA), 32'd1);
        end
        sendSparse(32'h4B5A6978);
        checkOutput("A sparse init", 32'(initA), 32'd1);
        checkOutput("A sparse writes left", 32'(expQ.size()), 32'd0);
        checkOutput("A sparse ack count", 32'(ackCnt[0]), 32'd4);

        resetA = 1'b1;
        @(negedge clock);
        resetA = 1'b0;
        pushWord(0, 21'h100, 32'hCAFEF00D);
        bootA = 32'hCAFEF00D; reqA = 1'b1;
        n = 0;
        while (!(sramAddrA == 21'h102 && !weA) && n < 80) begin @(negedge clock); n++; end
        checkOutput("A byte2 strobe seen", 32'(sramAddrA == 21'h102 && !weA), 32'd1);
        #2;
        resetA = 1'b1; reqA = 1'b0;
        #1;
        checkOutput("A mid rst we_n", 32'(weA), 32'd1);
        checkOutput("A mid rst hold", 32'(holdA), 32'd1);
        checkOutput("A mid rst oe", 32'(oeA), 32'd0);
        checkOutput("A mid rst addr", 32'(sramAddrA), 32'h100);
        repeat (2) @(negedge clock);
        expQ.delete();
        ackQ.delete();
        resetA = 1'b0;
        @(negedge clock);
        pushWord(0, 21'h100, 32'h01020304);
        pushWord(0, 21'h104, 32'h05060708);
        applyStimulus(0, 32'h01020304, 32'h05060708, 35);
        checkOutput("A restart writes left", 32'(expQ.size()), 32'd0);
        checkOutput("A restart ack count", 32'(ackCnt[0]), 32'd7);

        // One word of four 5-clock bytes after its CAPTURE clock: 21 edges.
        resetB = 1'b0;
        @(negedge clock);
        pushWrite(1, 21'h1FFFFE, 8'hDE); pushWrite(1, 21'h1FFFFF, 8'hAD);
        pushWrite(1, 21'h000000, 8'hBE); pushWrite(1, 21'h000001, 8'hEF);
        ackQ.push_back(1);
        applyStimulus(1, 32'hDEADBEEF, 32'hDEADBEEF, 21);
        checkOutput("B done init", 32'(initB), 32'd1);
        checkOutput("B done hold", 32'(holdB), 32'd0);
        checkOutput("B writes left", 32'(expQ.size()), 32'd0);
        checkOutput("B ack count", 32'(ackCnt[1]), 32'd1);

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end
endmodule
